// File: rtl/asrv32_regfile_arbiter_if.sv
// Request, response and register-file-side signals of the regfile arbiter.
// The arbiter takes the slave view; requesters and the register file together take the master view.
interface asrv32_regfile_arbiter_if;
   logic        i_core_rd_valid;
   logic        o_core_rd_ready;
   logic [4:0]  i_core_rs1_addr;
   logic [4:0]  i_core_rs2_addr;
   logic        i_core_wr_valid;
   logic        o_core_wr_ready;
   logic [4:0]  i_core_wr_addr;
   logic [31:0] i_core_wr_data;
   logic        i_dbg_rd_valid;
   logic        o_dbg_rd_ready;
   logic [4:0]  i_dbg_rs1_addr;
   logic [4:0]  i_dbg_rs2_addr;
   logic        i_dbg_wr_valid;
   logic        o_dbg_wr_ready;
   logic [4:0]  i_dbg_wr_addr;
   logic [31:0] i_dbg_wr_data;
   logic        o_rsp_valid;
   logic        o_rsp_id;
   logic [31:0] o_rsp_rs1_data;
   logic [31:0] o_rsp_rs2_data;
   logic        o_rf_ce_rd;
   logic        o_rf_ce_wr;
   logic [4:0]  o_rf_rs1_addr;
   logic [4:0]  o_rf_rs2_addr;
   logic [4:0]  o_rf_rd_addr;
   logic [31:0] o_rf_rd_data;
   logic [31:0] i_rf_rs1_data;
   logic [31:0] i_rf_rs2_data;

   modport slave (
      input  i_core_rd_valid, i_core_rs1_addr, i_core_rs2_addr,
      input  i_core_wr_valid, i_core_wr_addr, i_core_wr_data,
      input  i_dbg_rd_valid, i_dbg_rs1_addr, i_dbg_rs2_addr,
      input  i_dbg_wr_valid, i_dbg_wr_addr, i_dbg_wr_data,
      input  i_rf_rs1_data, i_rf_rs2_data,
      output o_core_rd_ready, o_core_wr_ready, o_dbg_rd_ready, o_dbg_wr_ready,
      output o_rsp_valid, o_rsp_id, o_rsp_rs1_data, o_rsp_rs2_data,
      output o_rf_ce_rd, o_rf_ce_wr, o_rf_rs1_addr, o_rf_rs2_addr, o_rf_rd_addr, o_rf_rd_data
   );

   modport master (
      output i_core_rd_valid, i_core_rs1_addr, i_core_rs2_addr,
      output i_core_wr_valid, i_core_wr_addr, i_core_wr_data,
      output i_dbg_rd_valid, i_dbg_rs1_addr, i_dbg_rs2_addr,
      output i_dbg_wr_valid, i_dbg_wr_addr, i_dbg_wr_data,
      output i_rf_rs1_data, i_rf_rs2_data,
      input  o_core_rd_ready, o_core_wr_ready, o_dbg_rd_ready, o_dbg_wr_ready,
      input  o_rsp_valid, o_rsp_id, o_rsp_rs1_data, o_rsp_rs2_data,
      input  o_rf_ce_rd, o_rf_ce_wr, o_rf_rs1_addr, o_rf_rs2_addr, o_rf_rd_addr, o_rf_rd_data
   );
endinterface

// File: rtl/asrv32_regfile_arbiter.sv
// Core/debug arbiter for the regfile read and write ports; grants are combinational, read response 1 cycle later.
// No response backpressure. Define ASRV32_ARB_STARVE_EN for the debug starvation guard (strict core priority otherwise).
module asrv32_regfile_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input logic                    i_clk,
   input logic                    i_rst_n,
   asrv32_regfile_arbiter_if.slave bus
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..15");
   end

   logic rd_core_v, rd_dbg_v, wr_core_v, wr_dbg_v;
   logic rd_core_gnt, rd_dbg_gnt, wr_core_gnt, wr_dbg_gnt;
   logic ovr_rd, ovr_wr;
   logic rsp_pending_q, rsp_pending_d;
   logic rsp_id_q, rsp_id_d;

   // Valids are masked by reset so every output is quiet while i_rst_n is low.
   always_comb begin
      rd_core_v   = i_rst_n & bus.i_core_rd_valid;
      rd_dbg_v    = i_rst_n & bus.i_dbg_rd_valid;
      wr_core_v   = i_rst_n & bus.i_core_wr_valid;
      wr_dbg_v    = i_rst_n & bus.i_dbg_wr_valid;
      rd_dbg_gnt  = rd_dbg_v & (~rd_core_v | ovr_rd);
      rd_core_gnt = rd_core_v & ~rd_dbg_gnt;
      wr_dbg_gnt  = wr_dbg_v & (~wr_core_v | ovr_wr);
      wr_core_gnt = wr_core_v & ~wr_dbg_gnt;
   end

   always_comb begin
      bus.o_core_rd_ready = rd_core_gnt;
      bus.o_dbg_rd_ready  = rd_dbg_gnt;
      bus.o_core_wr_ready = wr_core_gnt;
      bus.o_dbg_wr_ready  = wr_dbg_gnt;
      bus.o_rf_ce_rd      = rd_core_gnt | rd_dbg_gnt;
      bus.o_rf_ce_wr      = wr_core_gnt | wr_dbg_gnt;
      bus.o_rf_rs1_addr   = '0;
      bus.o_rf_rs2_addr   = '0;
      bus.o_rf_rd_addr    = '0;
      bus.o_rf_rd_data    = '0;
      if (rd_dbg_gnt) begin
         bus.o_rf_rs1_addr = bus.i_dbg_rs1_addr;
         bus.o_rf_rs2_addr = bus.i_dbg_rs2_addr;
      end else if (rd_core_gnt) begin
         bus.o_rf_rs1_addr = bus.i_core_rs1_addr;
         bus.o_rf_rs2_addr = bus.i_core_rs2_addr;
      end
      if (wr_dbg_gnt) begin
         bus.o_rf_rd_addr = bus.i_dbg_wr_addr;
         bus.o_rf_rd_data = bus.i_dbg_wr_data;
      end else if (wr_core_gnt) begin
         bus.o_rf_rd_addr = bus.i_core_wr_addr;
         bus.o_rf_rd_data = bus.i_core_wr_data;
      end
   end

`ifdef ASRV32_ARB_STARVE_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_rd_q, starve_rd_d;
   logic [3:0] starve_wr_q, starve_wr_d;

   assign ovr_rd = (starve_rd_q == LIMIT);
   assign ovr_wr = (starve_wr_q == LIMIT);

   // A counter parks at LIMIT until debug wins, so it never passes the limit.
   always_comb begin
      starve_rd_d = starve_rd_q;
      starve_wr_d = starve_wr_q;
      if (!rd_dbg_v || rd_dbg_gnt) begin
         starve_rd_d = '0;
      end else if (rd_core_gnt && !ovr_rd) begin
         starve_rd_d = starve_rd_q + 4'd1;
      end
      if (!wr_dbg_v || wr_dbg_gnt) begin
         starve_wr_d = '0;
      end else if (wr_core_gnt && !ovr_wr) begin
         starve_wr_d = starve_wr_q + 4'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         starve_rd_q <= '0;
         starve_wr_q <= '0;
      end else begin
         starve_rd_q <= starve_rd_d;
         starve_wr_q <= starve_wr_d;
      end
   end
`else
   assign ovr_rd = 1'b0;
   assign ovr_wr = 1'b0;
`endif

   always_comb begin
      rsp_pending_d = rd_core_gnt | rd_dbg_gnt;
      rsp_id_d      = rd_dbg_gnt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_pending_q <= 1'b0;
         rsp_id_q      <= 1'b0;
      end else begin
         rsp_pending_q <= rsp_pending_d;
         rsp_id_q      <= rsp_id_d;
      end
   end

   // The regfile registers the read address itself; its data arrives with the pending flag.
   always_comb begin
      bus.o_rsp_valid    = rsp_pending_q;
      bus.o_rsp_id       = rsp_id_q;
      bus.o_rsp_rs1_data = i_rst_n ? bus.i_rf_rs1_data : 32'h0;
      bus.o_rsp_rs2_data = i_rst_n ? bus.i_rf_rs2_data : 32'h0;
   end

endmodule

// File: tb/tb_asrv32_regfile_arbiter.sv
// Directed bench for asrv32_regfile_arbiter with a write-first, sync-read register file model.
// Builds with or without ASRV32_ARB_STARVE_EN; starvation expectations follow the macro.
module tb_asrv32_regfile_arbiter;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;

   asrv32_regfile_arbiter_if bus();

   asrv32_regfile_arbiter #(.STARVE_LIMIT(4)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

`ifdef ASRV32_ARB_STARVE_EN
   localparam int STARVE_CYC = 5;
`else
   localparam int STARVE_CYC = 0;
`endif

   // Register file model: x0 reads zero, write lands before the same-edge read address is used.
   logic [31:0] mem [32] = '{default: 32'h0};
   logic [4:0]  rs1_lat = 5'd0;
   logic [4:0]  rs2_lat = 5'd0;

   always @(posedge i_clk) begin
      if (bus.o_rf_ce_wr && bus.o_rf_rd_addr != 5'd0) mem[bus.o_rf_rd_addr] <= bus.o_rf_rd_data;
      if (bus.o_rf_ce_rd) begin
         rs1_lat <= bus.o_rf_rs1_addr;
         rs2_lat <= bus.o_rf_rs2_addr;
      end
   end

   assign bus.i_rf_rs1_data = mem[rs1_lat];
   assign bus.i_rf_rs2_data = mem[rs2_lat];

   typedef struct packed {
      logic        crv;
      logic [4:0]  c1;
      logic [4:0]  c2;
      logic        cwv;
      logic [4:0]  cwa;
      logic [31:0] cwd;
      logic        drv;
      logic [4:0]  d1;
      logic [4:0]  d2;
      logic        dwv;
      logic [4:0]  dwa;
      logic [31:0] dwd;
      logic [3:0]  e_rdy;   // {core_rd, core_wr, dbg_rd, dbg_wr}
      logic [4:0]  e_rs1;
      logic [4:0]  e_rs2;
      logic [4:0]  e_rd;
      logic [31:0] e_wd;
      logic        e_rv;
      logic        e_rid;
      logic [31:0] e_r1;
      logic [31:0] e_r2;
   } vec_t;

   vec_t vecs [15];
   vec_t sv;
   vec_t rv;
   int   n_cmp = 0;
   int   n_err = 0;
   logic dbg_done = 1'b0;
   logic dbg_prev = 1'b0;
   logic exp_d;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.i_core_rd_valid = v.crv;
      bus.i_core_rs1_addr = v.c1;
      bus.i_core_rs2_addr = v.c2;
      bus.i_core_wr_valid = v.cwv;
      bus.i_core_wr_addr  = v.cwa;
      bus.i_core_wr_data  = v.cwd;
      bus.i_dbg_rd_valid  = v.drv;
      bus.i_dbg_rs1_addr  = v.d1;
      bus.i_dbg_rs2_addr  = v.d2;
      bus.i_dbg_wr_valid  = v.dwv;
      bus.i_dbg_wr_addr   = v.dwa;
      bus.i_dbg_wr_data   = v.dwd;
   endtask

   function automatic logic [52:0] gvec();
      return {bus.o_core_rd_ready, bus.o_core_wr_ready, bus.o_dbg_rd_ready, bus.o_dbg_wr_ready,
              bus.o_rf_ce_rd, bus.o_rf_ce_wr, bus.o_rf_rs1_addr, bus.o_rf_rs2_addr,
              bus.o_rf_rd_addr, bus.o_rf_rd_data};
   endfunction

   function automatic logic [65:0] rvec();
      return {bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_rs1_data, bus.o_rsp_rs2_data};
   endfunction

   initial begin
      //          crv  c1    c2    cwv  cwa   cwd            drv  d1    d2    dwv  dwa   dwd            rdy      rs1   rs2   rd    wd             rv   rid  r1             r2
      vecs[0]  = '{1'b0,5'd0, 5'd0, 1'b1,5'd5, 32'hDEADBEEF, 1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        4'b0100, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0,1'b0,32'h0,        32'h0};
      vecs[1]  = '{1'b0,5'd0, 5'd0, 1'b1,5'd6, 32'h12345678, 1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        4'b0100, 5'd0, 5'd0, 5'd6, 32'h12345678, 1'b0,1'b0,32'h0,        32'h0};
      vecs[2]  = '{1'b1,5'd5, 5'd6, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        4'b1000, 5'd5, 5'd6, 5'd0, 32'h0,        1'b0,1'b0,32'h0,        32'h0};
      vecs[3]  = '{1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        4'b0000, 5'd0, 5'd0, 5'd0, 32'h0,        1'b1,1'b0,32'hDEADBEEF, 32'h12345678};
      vecs[4]  = '{1'b0,5'd0, 5'd0, 1'b1,5'd3, 32'h11,       1'b0,5'd0, 5'd0, 1'b1,5'd4, 32'h22,       4'b0100, 5'd0, 5'd0, 5'd3, 32'h11,       1'b0,1'b0,32'h0,        32'h0};
      vecs[5]  = '{1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 1'b1,5'd4, 32'h22,       4'b0001, 5'd0, 5'd0, 5'd4, 32'h22,       1'b0,1'b0,32'h0,        32'h0};
      vecs[6]  = '{1'b1,5'd3, 5'd4, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        4'b1000, 5'd3, 5'd4, 5'd0, 32'h0,        1'b0,1'b0,32'h0,        32'h0};
      vecs[7]  = '{1'b0,5'd0, 5'd0, 1'b1,5'd7, 32'hA5A5A5A5, 1'b1,5'd7, 5'd7, 1'b0,5'd0, 32'h0,        4'b0110, 5'd7, 5'd7, 5'd7, 32'hA5A5A5A5, 1'b1,1'b0,32'h11,       32'h22};
      vecs[8]  = '{1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 1'b1,5'd0, 32'hFFFFFFFF, 4'b0001, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1,1'b1,32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[9]  = '{1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        1'b1,5'd0, 5'd3, 1'b0,5'd0, 32'h0,        4'b0010, 5'd0, 5'd3, 5'd0, 32'h0,        1'b0,1'b0,32'h0,        32'h0};
      vecs[10] = '{1'b1,5'd5, 5'd7, 1'b0,5'd0, 32'h0,        1'b1,5'd1, 5'd2, 1'b0,5'd0, 32'h0,        4'b1000, 5'd5, 5'd7, 5'd0, 32'h0,        1'b1,1'b1,32'h0,        32'h11};
      vecs[11] = '{1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        1'b1,5'd1, 5'd2, 1'b0,5'd0, 32'h0,        4'b0010, 5'd1, 5'd2, 5'd0, 32'h0,        1'b1,1'b0,32'hDEADBEEF, 32'hA5A5A5A5};
      vecs[12] = '{1'b1,5'd1, 5'd2, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 1'b1,5'd2, 32'h0000BEEF, 4'b1001, 5'd1, 5'd2, 5'd2, 32'h0000BEEF, 1'b1,1'b1,32'h0,        32'h0};
      vecs[13] = '{1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        4'b0000, 5'd0, 5'd0, 5'd0, 32'h0,        1'b1,1'b0,32'h0,        32'h0000BEEF};
      vecs[14] = '{1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        1'b0,5'd0, 5'd0, 1'b0,5'd0, 32'h0,        4'b0000, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0,1'b0,32'h0,        32'h0};

      // Reset held with every valid high; x0 is the only write target so nothing real is written.
      rv = '0;
      rv.crv = 1'b1; rv.cwv = 1'b1; rv.cwd = 32'hFFFFFFFF;
      rv.drv = 1'b1; rv.dwv = 1'b1; rv.dwd = 32'hFFFFFFFF;
      drive(rv);
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_outputs", {gvec(), rvec()}, '0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      chk("release_grant", gvec(), {4'b1100, 2'b11, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF});
      @(posedge i_clk);
      #1;
      chk("release_rsp", rvec(), {1'b1, 1'b0, 64'h0});
      drive('0);

      for (int i = 0; i < 15; i++) begin
         @(posedge i_clk);
         #1;
         drive(vecs[i]);
         #1;
         chk($sformatf("row%0d_grant", i), gvec(),
             {vecs[i].e_rdy, vecs[i].e_rdy[3] | vecs[i].e_rdy[1], vecs[i].e_rdy[2] | vecs[i].e_rdy[0],
              vecs[i].e_rs1, vecs[i].e_rs2, vecs[i].e_rd, vecs[i].e_wd});
         if (vecs[i].e_rv)
            chk($sformatf("row%0d_rsp", i), rvec(), {1'b1, vecs[i].e_rid, vecs[i].e_r1, vecs[i].e_r2});
         else
            chk($sformatf("row%0d_rsp_valid", i), bus.o_rsp_valid, 1'b0);
      end

      // Core reads every cycle while debug waits on the read channel.
      sv = '0;
      sv.crv = 1'b1; sv.c1 = 5'd5; sv.c2 = 5'd6;
      sv.d1 = 5'd3; sv.d2 = 5'd4;
      for (int k = 1; k <= 8; k++) begin
         @(posedge i_clk);
         #1;
         sv.drv = !dbg_done;
         drive(sv);
         #1;
         if (dbg_prev)
            chk("starve_dbg_rsp", rvec(), {1'b1, 1'b1, 32'h11, 32'h22});
         else if (k > 1)
            chk("starve_core_rsp", rvec(), {1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678});
         exp_d = (k == STARVE_CYC);
         chk($sformatf("starve_rdy_c%0d", k), {bus.o_core_rd_ready, bus.o_dbg_rd_ready}, {!exp_d, exp_d});
         if (exp_d) dbg_done = 1'b1;
         dbg_prev = exp_d;
      end
      @(posedge i_clk);
      #1;
      sv.crv = 1'b0;
      sv.drv = !dbg_done;
      drive(sv);
      #1;
      chk("core_drop_rdy", {bus.o_core_rd_ready, bus.o_dbg_rd_ready}, {1'b0, !dbg_done});
      @(posedge i_clk);
      #1;
      drive('0);
      if (!dbg_done)
         chk("core_drop_rsp", rvec(), {1'b1, 1'b1, 32'h11, 32'h22});
      else
         chk("core_drop_rsp_valid", bus.o_rsp_valid, 1'b0);

      // Reset lands while a read response is pending.
      @(posedge i_clk);
      #1;
      sv = '0;
      sv.crv = 1'b1; sv.c1 = 5'd5; sv.c2 = 5'd6;
      drive(sv);
      @(posedge i_clk);
      #1;
      chk("pre_reset_rsp_valid", bus.o_rsp_valid, 1'b1);
      i_rst_n = 1'b0;
      drive('0);
      #1;
      chk("mid_reset_outputs", {gvec(), bus.o_rsp_valid}, '0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      chk("post_reset_rsp_valid_1", bus.o_rsp_valid, 1'b0);
      @(posedge i_clk);
      #1;
      chk("post_reset_rsp_valid_2", bus.o_rsp_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
